// File: rtl/ultimate_ttt_ctrl.sv
// ultimate_ttt_ctrl: meta-board controller for ultimate tic-tac-toe.
// Routes buttons to one sub-board at a time, tracks the meta-board and decides the game outcome.
module ultimate_ttt_ctrl (
    input  logic        Clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        BtnL,
    input  logic        BtnR,
    input  logic        BtnU,
    input  logic        BtnD,
    input  logic        BtnC,
    input  logic [8:0]  PM,
    input  logic [35:0] I_all,
    input  logic [8:0]  B1Won,
    input  logic [8:0]  B2Won,
    input  logic [8:0]  BFull,
    output logic [8:0]  active,
    output logic [8:0]  board_restart,
    output logic        Player,
    output logic [3:0]  sel_cursor,
    output logic [8:0]  M1,
    output logic [8:0]  M2,
    output logic        GameWon1,
    output logic        GameWon2,
    output logic        GameDraw
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PLAY   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [8:0]  active_r, active_s;
    logic [8:0]  brst_r, brst_s;
    logic        player_r, player_s;
    logic [3:0]  cursor_r, cursor_s;
    logic [8:0]  m1_r, m1_s;
    logic [8:0]  m2_r, m2_s;
    logic        won1_r, won1_s;
    logic        won2_r, won2_s;
    logic        draw_r, draw_s;
    logic [3:0]  next_board_r, next_board_s;
    logic [3:0]  cur_board_r, cur_board_s;
    logic [8:0]  closed_s;
    logic        pm_hit_s;
    logic        line1_s;
    logic        line2_s;

    function automatic logic meta_line(input logic [8:0] m);
        meta_line = (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
                    (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
                    (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    function automatic logic [8:0] onehot9(input logic [3:0] idx);
        onehot9 = 9'd0;
        if (idx <= 4'd8) begin
            onehot9[idx] = 1'b1;
        end else begin
            onehot9 = 9'd0;
        end
    endfunction

    // Indices beyond the grid count as closed so they fall back to free choice.
    function automatic logic board_open(input logic [8:0] closed, input logic [3:0] idx);
        if (idx <= 4'd8) begin
            board_open = ~closed[idx];
        end else begin
            board_open = 1'b0;
        end
    endfunction

    function automatic logic at_left(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd3, 4'd6: at_left = 1'b1;
            default:          at_left = 1'b0;
        endcase
    endfunction

    function automatic logic at_right(input logic [3:0] idx);
        case (idx)
            4'd2, 4'd5, 4'd8: at_right = 1'b1;
            default:          at_right = 1'b0;
        endcase
    endfunction

    assign closed_s = B1Won | B2Won | BFull;
    assign pm_hit_s = |(PM & active_r);
    assign line1_s  = meta_line(B1Won);
    assign line2_s  = meta_line(B2Won);

    // Next-state and next-output logic for the game controller.
    always_comb begin
        state_s      = state_r;
        active_s     = active_r;
        brst_s       = 9'd0;
        player_s     = player_r;
        cursor_s     = cursor_r;
        m1_s         = m1_r;
        m2_s         = m2_r;
        won1_s       = won1_r;
        won2_s       = won2_r;
        draw_s       = draw_r;
        next_board_s = next_board_r;
        cur_board_s  = cur_board_r;
        case (state_r)
            ST_INIT: begin
                active_s = 9'd0;
                state_s  = ST_SELECT;
            end
            ST_SELECT: begin
                active_s = 9'd0;
                if (BtnC) begin
                    if (board_open(closed_s, cursor_r)) begin
                        active_s    = onehot9(cursor_r);
                        cur_board_s = cursor_r;
                        state_s     = ST_PLAY;
                    end else begin
                        state_s = ST_SELECT;
                    end
                end else if (BtnU) begin
                    if (cursor_r >= 4'd3) cursor_s = cursor_r - 4'd3;
                    else                  cursor_s = cursor_r;
                end else if (BtnD) begin
                    if (cursor_r <= 4'd5) cursor_s = cursor_r + 4'd3;
                    else                  cursor_s = cursor_r;
                end else if (BtnL) begin
                    if (!at_left(cursor_r)) cursor_s = cursor_r - 4'd1;
                    else                    cursor_s = cursor_r;
                end else if (BtnR) begin
                    if (!at_right(cursor_r)) cursor_s = cursor_r + 4'd1;
                    else                     cursor_s = cursor_r;
                end else begin
                    cursor_s = cursor_r;
                end
            end
            ST_PLAY: begin
                if (pm_hit_s) begin
                    next_board_s = I_all[{cur_board_r, 2'b00} +: 4];
                    active_s     = 9'd0;
                    state_s      = ST_UPDATE;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_UPDATE: begin
                m1_s     = B1Won;
                m2_s     = B2Won;
                player_s = ~player_r;
                active_s = 9'd0;
                if (line1_s || line2_s) begin
                    won1_s  = line1_s;
                    won2_s  = line2_s;
                    state_s = ST_DONE;
                end else if (&closed_s) begin
                    draw_s  = 1'b1;
                    state_s = ST_DONE;
                end else if (board_open(closed_s, next_board_r)) begin
                    active_s    = onehot9(next_board_r);
                    cur_board_s = next_board_r;
                    state_s     = ST_PLAY;
                end else begin
                    // An off-grid target keeps the previous cursor rather than pointing nowhere.
                    if (next_board_r <= 4'd8) cursor_s = next_board_r;
                    else                      cursor_s = cursor_r;
                    state_s = ST_SELECT;
                end
            end
            ST_DONE: begin
                active_s = 9'd0;
                state_s  = ST_DONE;
            end
            default: begin
                active_s = 9'd0;
                brst_s   = 9'h1FF;
                state_s  = ST_INIT;
            end
        endcase
    end

    // State and output registers; reset and restart both start a fresh game.
    always_ff @(posedge Clk) begin
        if (reset || restart) begin
            state_r      <= ST_INIT;
            active_r     <= 9'd0;
            brst_r       <= 9'h1FF;
            player_r     <= 1'b0;
            cursor_r     <= 4'd4;
            m1_r         <= 9'd0;
            m2_r         <= 9'd0;
            won1_r       <= 1'b0;
            won2_r       <= 1'b0;
            draw_r       <= 1'b0;
            next_board_r <= 4'd0;
            cur_board_r  <= 4'd0;
        end else begin
            state_r      <= state_s;
            active_r     <= active_s;
            brst_r       <= brst_s;
            player_r     <= player_s;
            cursor_r     <= cursor_s;
            m1_r         <= m1_s;
            m2_r         <= m2_s;
            won1_r       <= won1_s;
            won2_r       <= won2_s;
            draw_r       <= draw_s;
            next_board_r <= next_board_s;
            cur_board_r  <= cur_board_s;
        end
    end

    assign active        = active_r;
    assign board_restart = brst_r;
    assign Player        = player_r;
    assign sel_cursor    = cursor_r;
    assign M1            = m1_r;
    assign M2            = m2_r;
    assign GameWon1      = won1_r;
    assign GameWon2      = won2_r;
    assign GameDraw      = draw_r;

endmodule

// File: doc/ultimate_ttt_ctrl.md
ULTIMATE_TTT_CTRL -- requirements
Module: ultimate_ttt_ctrl

Interface
REQ-001 SHALL have port Clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high; clears all state.
REQ-003 SHALL have port restart  input  1  synchronous, active-high; new game, same effect as reset, reset has priority.
REQ-004 SHALL have ports BtnL, BtnR, BtnU, BtnD, BtnC  input  1 each  debounced single-cycle button pulses.
REQ-005 SHALL have port PM  input  9  PlayerMoved pulse from each sub-board, bit k = board k.
REQ-006 SHALL have port I_all  input  36  cursor/cell index of each sub-board, bits [4k+3:4k] = board k.
REQ-007 SHALL have ports B1Won, B2Won, BFull  input  9 each  per-board P1-won, P2-won and full flags.
REQ-008 SHALL have port active  output  9  one-hot enable of the board receiving buttons; 0 when none.
REQ-009 SHALL have port board_restart  output  9  restart pulse to sub-boards.
REQ-010 SHALL have port Player  output  1  player to move: 0 = P1, 1 = P2.
REQ-011 SHALL have port sel_cursor  output  4  highlighted board index (0-8, row-major) in SELECT.
REQ-012 SHALL have ports M1, M2  output  9 each  meta-board: boards won by P1 / P2.
REQ-013 SHALL have ports GameWon1, GameWon2, GameDraw  output  1 each  game-over outcome flags.

Function
REQ-014 SHALL implement states INIT, SELECT, PLAY, UPDATE, DONE.
REQ-015 INIT SHALL last one cycle, drive board_restart = 9'h1FF, then go to SELECT; board_restart SHALL be 0 in all other states.
REQ-016 SELECT: BtnL/BtnR SHALL move sel_cursor -/+1 within its row, BtnU/BtnD -/+3; moves off the grid edge SHALL saturate (no wrap).
REQ-017 Simultaneous buttons SHALL be resolved with priority C > U > D > L > R, one action per cycle.
REQ-018 SELECT: BtnC on an open board (not B1Won|B2Won|BFull) SHALL set that board active and enter PLAY next cycle; BtnC on a closed board SHALL be ignored.
REQ-019 PLAY: active SHALL be one-hot for the current board; buttons are consumed only by that board, not by the controller.
REQ-020 PLAY: a PM pulse from the active board SHALL latch its I_all cell index as next_board and enter UPDATE; PM from any other board, or PM in any other state, SHALL be ignored.
REQ-021 UPDATE (one cycle): active = 0; M1/M2 SHALL be loaded from B1Won/B2Won; Player SHALL toggle.
REQ-022 UPDATE: meta-win SHALL be tested on M1/M2 over 8 lines (3 rows, 3 cols, 2 diagonals); a line for P1 sets GameWon1, for P2 sets GameWon2, then DONE.
REQ-023 UPDATE, no meta-win, all 9 boards closed: set GameDraw, go DONE.
REQ-024 UPDATE, otherwise: if board next_board open, make it active and enter PLAY; if closed, set sel_cursor = next_board and enter SELECT (free choice).
REQ-025 Latency: PM at edge n -> UPDATE during cycle n+1 -> new active (or SELECT) from edge n+2; sub-board flags SHALL be sampled in UPDATE.
REQ-026 next_board values > 8 SHALL be treated as closed (free choice).
REQ-027 DONE SHALL hold all outputs, active = 0, and ignore buttons and PM until reset/restart.

Reset
REQ-028 On reset or restart: state = INIT, active = 0, Player = 0, sel_cursor = 4, M1 = M2 = 0, GameWon1 = GameWon2 = GameDraw = 0, next_board = 0.
REQ-029 Reset/restart asserted in any state, including mid-PLAY or with PM pulsing, SHALL override all other activity that cycle.

Verification
REQ-030 Reset, then BtnU, BtnL, BtnC -> sel_cursor 4->1->0; active = 9'h001, Player = 0 two cycles after BtnC.
REQ-031 Board 0 active, PM[0] pulse with cell 5 -> UPDATE next cycle, then active = 9'h020, Player = 1; PM[3] in PLAY -> no change.
REQ-032 Move targets cell 2 with BFull[2] = 1 -> SELECT with sel_cursor = 2; BtnC there ignored; BtnR at cursor 2 stays 2; BtnD to 5, BtnC -> active = 9'h020.
REQ-033 B1Won = 9'b001_010_100 (diagonal 2,4,6) seen in UPDATE -> GameWon1 = 1, M1 = 9'h054, DONE; later buttons/PM leave outputs unchanged.
REQ-034 All BFull set, no meta line -> GameDraw = 1, GameWon1 = GameWon2 = 0.
REQ-035 restart asserted mid-PLAY with simultaneous PM -> INIT, board_restart = 9'h1FF for one cycle, all outputs at reset values.
